// File: rtl/imm_pkg.sv
// Shared types and constants for the immediate-table writer and its decoder.
package imm_pkg;

    // Format tag written alongside every table entry.
    typedef enum logic [2:0] {
        KindNone = 3'd0,
        KindI    = 3'd1,
        KindS    = 3'd2,
        KindB    = 3'd3,
        KindU    = 3'd4,
        KindJ    = 3'd5
    } imm_kind_e;

    // RV32I major opcodes, inst[6:0].
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    // Load-session sequencing.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLoad  = 2'd1,
        StFlush = 2'd2,
        StDone  = 2'd3
    } wr_state_e;

    // Instruction address of table entry idx: entries are consecutive 32-bit words.
    function automatic logic [31:0] entry_addr(input logic [31:0] base, input logic [31:0] idx);
        return base + (idx << 2);
    endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational RV32I immediate extractor. Returns the raw (unextended) immediate
// fields for the instruction's format; fields that do not apply are zero.
module imm_decode
    import imm_pkg::*;
(
    input  logic [31:0] inst,
    output imm_kind_e   kind,
    output logic [11:0] imm12,
    output logic [19:0] imm20,
    output logic [31:0] imm32,
    output logic        illegal
);

    // Select format by opcode and gather the scattered immediate bits.
    always_comb begin
        kind    = KindNone;
        imm12   = '0;
        imm20   = '0;
        imm32   = '0;
        illegal = 1'b0;
        case (inst[6:0])
            OP_LOAD, OP_IMM, OP_JALR: begin
                kind  = KindI;
                imm12 = inst[31:20];
            end
            OP_STORE: begin
                kind  = KindS;
                imm12 = {inst[31:25], inst[11:7]};
            end
            OP_BRANCH: begin
                // Bits [12:1] of the branch offset; bit 0 is implicitly zero.
                kind  = KindB;
                imm12 = {inst[31], inst[7], inst[30:25], inst[11:8]};
            end
            OP_LUI, OP_AUIPC: begin
                kind  = KindU;
                imm32 = {inst[31:12], 12'h000};
            end
            OP_JAL: begin
                // Bits [20:1] of the jump offset.
                kind  = KindJ;
                imm20 = {inst[31], inst[19:12], inst[20], inst[30:21]};
            end
            OP_REG: begin
                // Register-register ops carry no immediate but are legal.
                kind = KindNone;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_table_writer.sv
// Loads a stream of RV32I instruction words into the per-instruction immediate
// table: one registered table write per accepted beat, starting at BASE_ADDR.
module imm_table_writer
    import imm_pkg::*;
#(
    parameter int unsigned DEPTH     = 37,
    parameter int unsigned BASE_ADDR = 40,
    parameter int unsigned IDX_W     = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic             in_last,
    output logic             wr_en,
    output logic [IDX_W-1:0] wr_index,
    output logic [31:0]      wr_addr,
    output logic [2:0]       wr_kind,
    output logic [11:0]      wr_imm12,
    output logic [19:0]      wr_imm20,
    output logic [31:0]      wr_imm32,
    output logic             busy,
    output logic             done,
    output logic             err_opcode,
    output logic             err_overflow,
    output logic [IDX_W:0]   count
);

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(DEPTH - 1);

    wr_state_e        state_q, state_d;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W:0]   count_q;
    logic             err_opcode_q;
    logic             err_overflow_q;

    logic             wr_en_q;
    logic [IDX_W-1:0] wr_index_q;
    logic [31:0]      wr_addr_q;
    logic [2:0]       wr_kind_q;
    logic [11:0]      wr_imm12_q;
    logic [19:0]      wr_imm20_q;
    logic [31:0]      wr_imm32_q;

    imm_kind_e        dec_kind;
    logic [11:0]      dec_imm12;
    logic [19:0]      dec_imm20;
    logic [31:0]      dec_imm32;
    logic             dec_illegal;

    logic             accept;
    logic             at_end;
    logic             session_start;

    imm_decode u_decode (
        .inst    (in_inst),
        .kind    (dec_kind),
        .imm12   (dec_imm12),
        .imm20   (dec_imm20),
        .imm32   (dec_imm32),
        .illegal (dec_illegal)
    );

    assign in_ready      = (state_q == StLoad);
    assign accept        = in_valid & in_ready;
    assign at_end        = (idx_q == LastIdx);
    assign session_start = (state_q == StIdle) & start;

    // Next-state logic for the load session.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = StLoad;
            end
            StLoad: begin
                // A full table ends the session even without in_last.
                if (accept && (in_last || at_end)) state_d = StFlush;
            end
            StFlush: begin
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Session bookkeeping: entry index, count and sticky error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q          <= '0;
            count_q        <= '0;
            err_opcode_q   <= 1'b0;
            err_overflow_q <= 1'b0;
        end else if (session_start) begin
            idx_q          <= '0;
            count_q        <= '0;
            err_opcode_q   <= 1'b0;
            err_overflow_q <= 1'b0;
        end else if (accept) begin
            idx_q   <= idx_q + IDX_W'(1);
            count_q <= count_q + (IDX_W + 1)'(1);
            if (dec_illegal) err_opcode_q <= 1'b1;
            if (at_end && !in_last) err_overflow_q <= 1'b1;
        end
    end

    // Registered write port; fields hold their last value between writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en_q    <= 1'b0;
            wr_index_q <= '0;
            wr_addr_q  <= '0;
            wr_kind_q  <= '0;
            wr_imm12_q <= '0;
            wr_imm20_q <= '0;
            wr_imm32_q <= '0;
        end else begin
            wr_en_q <= accept;
            if (accept) begin
                wr_index_q <= idx_q;
                wr_addr_q  <= entry_addr(32'(BASE_ADDR), 32'(idx_q));
                wr_kind_q  <= dec_kind;
                wr_imm12_q <= dec_imm12;
                wr_imm20_q <= dec_imm20;
                wr_imm32_q <= dec_imm32;
            end
        end
    end

    assign wr_en        = wr_en_q;
    assign wr_index     = wr_index_q;
    assign wr_addr      = wr_addr_q;
    assign wr_kind      = wr_kind_q;
    assign wr_imm12     = wr_imm12_q;
    assign wr_imm20     = wr_imm20_q;
    assign wr_imm32     = wr_imm32_q;
    assign busy         = (state_q != StIdle);
    assign done         = (state_q == StDone);
    assign err_opcode   = err_opcode_q;
    assign err_overflow = err_overflow_q;
    assign count        = count_q;

endmodule

// File: tb/tb_imm_table_writer.sv
// Scoreboard bench for imm_table_writer: each accepted beat pushes its expected
// table write; a negedge monitor pops and compares every wr_en cycle.
module tb_imm_table_writer;

    localparam int unsigned DEPTH     = 37;
    localparam int unsigned BASE_ADDR = 40;
    localparam int unsigned IDX_W     = 6;

    logic             clk;
    logic             reset;
    logic             start;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_inst;
    logic             in_last;
    logic             wr_en;
    logic [IDX_W-1:0] wr_index;
    logic [31:0]      wr_addr;
    logic [2:0]       wr_kind;
    logic [11:0]      wr_imm12;
    logic [19:0]      wr_imm20;
    logic [31:0]      wr_imm32;
    logic             busy;
    logic             done;
    logic             err_opcode;
    logic             err_overflow;
    logic [IDX_W:0]   count;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [31:0]      addr;
        logic [2:0]       kind;
        logic [11:0]      imm12;
        logic [19:0]      imm20;
        logic [31:0]      imm32;
    } wr_exp_t;

    wr_exp_t sb_q[$];
    int      n_checks = 0;
    int      n_errors = 0;
    int      exp_idx  = 0;

    imm_table_writer #(
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE_ADDR),
        .IDX_W     (IDX_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_inst      (in_inst),
        .in_last      (in_last),
        .wr_en        (wr_en),
        .wr_index     (wr_index),
        .wr_addr      (wr_addr),
        .wr_kind      (wr_kind),
        .wr_imm12     (wr_imm12),
        .wr_imm20     (wr_imm20),
        .wr_imm32     (wr_imm32),
        .busy         (busy),
        .done         (done),
        .err_opcode   (err_opcode),
        .err_overflow (err_overflow),
        .count        (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Reference decode of one instruction word into its expected table entry.
    function automatic wr_exp_t model(input int idx, input logic [31:0] w);
        wr_exp_t e;
        e       = '0;
        e.idx   = IDX_W'(idx);
        e.addr  = 32'(BASE_ADDR + 4 * idx);
        case (w[6:0])
            7'h03, 7'h13, 7'h67: begin
                e.kind  = 3'd1;
                e.imm12 = w[31:20];
            end
            7'h23: begin
                e.kind  = 3'd2;
                e.imm12 = {w[31:25], w[11:7]};
            end
            7'h63: begin
                e.kind  = 3'd3;
                e.imm12 = {w[31], w[7], w[30:25], w[11:8]};
            end
            7'h37, 7'h17: begin
                e.kind  = 3'd4;
                e.imm32 = {w[31:12], 12'h000};
            end
            7'h6f: begin
                e.kind  = 3'd5;
                e.imm20 = {w[31], w[19:12], w[20], w[30:21]};
            end
            default: e.kind = 3'd0;
        endcase
        return e;
    endfunction

    // Monitor: every write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        wr_exp_t e;
        if (wr_en === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_write", 32'(wr_index), 32'hFFFF_FFFF);
            end else begin
                e = sb_q.pop_front();
                check("wr_index", 32'(wr_index), 32'(e.idx));
                check("wr_addr",  wr_addr,       e.addr);
                check("wr_kind",  32'(wr_kind),  32'(e.kind));
                check("wr_imm12", 32'(wr_imm12), 32'(e.imm12));
                check("wr_imm20", 32'(wr_imm20), 32'(e.imm20));
                check("wr_imm32", wr_imm32,      e.imm32);
            end
        end
    end

    task automatic start_session();
        start = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        exp_idx = 0;
        check("sess_busy",     32'(busy),         32'd1);
        check("sess_ready",    32'(in_ready),     32'd1);
        check("sess_count",    32'(count),        32'd0);
        check("sess_err_op",   32'(err_opcode),   32'd0);
        check("sess_err_ovf",  32'(err_overflow), 32'd0);
    endtask

    // Present one beat and hold it until accepted; returns 1ns after the accepting edge.
    task automatic send(input logic [31:0] w, input logic last);
        int n = 0;
        in_valid = 1'b1;
        in_inst  = w;
        in_last  = last;
        while (in_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (in_ready !== 1'b1) begin
            check("accept_timeout", 32'(in_ready), 32'd1);
        end else begin
            sb_q.push_back(model(exp_idx, w));
            exp_idx++;
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_done();
        int n = 0;
        while (done !== 1'b1 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check("done_pulse", 32'(done), 32'd1);
        @(posedge clk); #1;
        check("done_one_cycle", 32'(done), 32'd0);
        check("idle_busy",      32'(busy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        clk      = 1'b0;
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_inst  = '0;
        in_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready",   32'(in_ready), 32'd0);
        check("rst_wr_en",   32'(wr_en),    32'd0);
        check("rst_busy",    32'(busy),     32'd0);
        check("rst_done",    32'(done),     32'd0);
        check("rst_count",   32'(count),    32'd0);
        check("rst_err",     32'({err_opcode, err_overflow}), 32'd0);
        check("rst_wr_addr", wr_addr,       32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Single addi beat.
        start_session();
        send(32'h0190_0093, 1'b1);
        in_valid = 1'b0;
        check("t1_wr_en",  32'(wr_en),    32'd1);
        check("t1_idx",    32'(wr_index), 32'd0);
        check("t1_addr",   wr_addr,       32'd40);
        check("t1_kind",   32'(wr_kind),  32'd1);
        check("t1_imm12",  32'(wr_imm12), 32'h019);
        check("t1_ready",  32'(in_ready), 32'd0);
        check("t1_nodone", 32'(done),     32'd0);
        @(posedge clk); #1;
        check("t1_done",   32'(done),     32'd1);
        check("t1_count",  32'(count),    32'd1);
        check("t1_wr_off", 32'(wr_en),    32'd0);
        check("t1_hold",   32'(wr_imm12), 32'h019);
        @(posedge clk); #1;
        check("t1_done_end", 32'(done),   32'd0);

        // Back-to-back jal, lui, sw.
        start_session();
        send(32'h0F60_00EF, 1'b0);
        check("t2_jal_imm20", 32'(wr_imm20), 32'd123);
        send(32'h000F_62B7, 1'b0);
        check("t2_lui_imm32", wr_imm32, 32'h000F_6000);
        check("t2_lui_addr",  wr_addr,  32'd44);
        send(32'h0020_A423, 1'b1);
        in_valid = 1'b0;
        check("t2_sw_imm12",  32'(wr_imm12), 32'd8);
        check("t2_sw_addr",   wr_addr,       32'd48);
        wait_done();
        check("t2_count",     32'(count),    32'd3);

        // Valid toggling 1,0,1 with a branch and a load.
        start_session();
        send(32'hFE00_8EE3, 1'b0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("t3_gap_wr_en", 32'(wr_en), 32'd0);
        send(32'h0081_2183, 1'b1);
        in_valid = 1'b0;
        check("t3_idx",       32'(wr_index), 32'd1);
        wait_done();
        check("t3_count",     32'(count), 32'd2);

        // Unrecognised opcode.
        start_session();
        send(32'hFFFF_FFFF, 1'b1);
        in_valid = 1'b0;
        check("t4_kind",      32'(wr_kind),    32'd0);
        check("t4_imm",       32'(wr_imm12) | 32'(wr_imm20) | wr_imm32, 32'd0);
        check("t4_err_op",    32'(err_opcode), 32'd1);
        wait_done();
        check("t4_err_held",  32'(err_opcode), 32'd1);

        // Overflow: DEPTH beats with no in_last (start also clears err_opcode).
        start_session();
        for (int i = 0; i < int'(DEPTH); i++) begin
            case (i % 4)
                0: send(32'h0190_0093, 1'b0);
                1: send(32'h0F60_00EF, 1'b0);
                2: send(32'h000F_62B7, 1'b0);
                default: send(32'h0020_A423, 1'b0);
            endcase
        end
        // Keep offering beats: none may be taken after the table fills.
        check("t5_ready",     32'(in_ready),     32'd0);
        check("t5_err_ovf",   32'(err_overflow), 32'd1);
        check("t5_count",     32'(count),        32'd37);
        check("t5_last_addr", wr_addr,           32'd184);
        check("t5_last_idx",  32'(wr_index),     32'd36);
        wait_done();
        in_valid = 1'b0;
        check("t5_sb_empty",  32'(sb_q.size()),  32'd0);

        // Reset after 2 of 5 beats.
        start_session();
        send(32'h0190_0093, 1'b0);
        send(32'h0F60_00EF, 1'b0);
        in_inst  = 32'h000F_62B7;
        in_valid = 1'b1;
        reset    = 1'b1;
        @(posedge clk); #1;
        check("t6_wr_en",   32'(wr_en),    32'd0);
        check("t6_idx",     32'(wr_index), 32'd0);
        check("t6_addr",    wr_addr,       32'd0);
        check("t6_fields",  32'(wr_kind) | 32'(wr_imm12) | 32'(wr_imm20) | wr_imm32, 32'd0);
        check("t6_count",   32'(count),    32'd0);
        check("t6_busy",    32'(busy),     32'd0);
        check("t6_ready",   32'(in_ready), 32'd0);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("t6_sb_empty", 32'(sb_q.size()), 32'd0);
        start_session();
        send(32'h000F_62B7, 1'b1);
        in_valid = 1'b0;
        check("t6_new_idx",  32'(wr_index), 32'd0);
        check("t6_new_addr", wr_addr,       32'd40);
        wait_done();

        check("sb_final", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
